// File: rtl/cla_pipe_ov_pkg.sv
// rtl/cla_pipe_ov_pkg.sv - shared ALU adder defaults, op encoding and flag helper
package cla_pipe_ov_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_STAGE_W = 8;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Signed overflow: carry out of the MSB disagrees with carry into it.
   function automatic logic ov_flag(input logic co, input logic c_msb);
      return co ^ c_msb;
   endfunction

endpackage

// File: rtl/cla_slice.sv
// rtl/cla_slice.sv - W-bit combinational carry-lookahead slice
module cla_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         c_msb,
   output logic         co
);

   logic [W-1:0] g;
   logic [W-1:0] p;
   logic [W:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // Each carry is the flat OR of generate terms, each propagated by the
   // AND of the propagates above it, so no carry depends on another carry.
   always_comb begin
      logic acc;
      logic prod;
      acc  = 1'b0;
      prod = 1'b0;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < W; i++) begin
         acc  = g[i];
         prod = p[i];
         for (int k = i - 1; k >= 0; k--) begin
            acc  = acc | (prod & g[k]);
            prod = prod & p[k];
         end
         acc      = acc | (prod & ci);
         c[i + 1] = acc;
      end
   end

   assign s     = p ^ c[W-1:0];
   assign co    = c[W];
   assign c_msb = c[W-1];

endmodule

// File: rtl/cla_pipe_ov.sv
// rtl/cla_pipe_ov.sv - pipelined carry-lookahead add/sub with carry, overflow and zero flags
module cla_pipe_ov
   import cla_pipe_ov_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int STAGE_W = DEF_STAGE_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_ci,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [WIDTH-1:0] o_s,
   output logic             o_co,
   output logic             o_c_msb,
   output logic             o_ov,
   output logic             o_z
);

   localparam int NSTAGE = WIDTH / STAGE_W;
   localparam int LAST   = NSTAGE - 1;

   logic [WIDTH-1:0] a_q  [NSTAGE];
   logic [WIDTH-1:0] b_q  [NSTAGE];
   logic [WIDTH-1:0] s_q  [NSTAGE];
   logic             c_q  [NSTAGE];
   logic             cm_q [NSTAGE];
   logic             v_q  [NSTAGE];

   logic             advance;
   logic [WIDTH-1:0] b_cond;
   logic             c0;

   assign advance = !v_q[LAST] || o_ready;
   assign i_ready = advance;

   // Subtract is A + ~B + 1; the caller's carry-in is dropped in that case.
   assign b_cond = (op_e'(i_sub) == OP_SUB) ? ~i_b : i_b;
   assign c0     = (op_e'(i_sub) == OP_SUB) ? 1'b1 : i_ci;

   for (genvar j = 0; j < NSTAGE; j++) begin : g_stage
      logic [WIDTH-1:0]   a_in;
      logic [WIDTH-1:0]   b_in;
      logic [WIDTH-1:0]   s_in;
      logic               c_in;
      logic               v_in;
      logic [STAGE_W-1:0] sl_s;
      logic               sl_cm;
      logic               sl_co;
      logic [WIDTH-1:0]   s_next;

      if (j == 0) begin : g_first
         assign a_in = i_a;
         assign b_in = b_cond;
         assign s_in = '0;
         assign c_in = c0;
         assign v_in = i_valid;
      end else begin : g_next
         assign a_in = a_q[j-1];
         assign b_in = b_q[j-1];
         assign s_in = s_q[j-1];
         assign c_in = c_q[j-1];
         assign v_in = v_q[j-1];
      end

      cla_slice #(
         .W (STAGE_W)
      ) u_slice (
         .a     (a_in[j*STAGE_W +: STAGE_W]),
         .b     (b_in[j*STAGE_W +: STAGE_W]),
         .ci    (c_in),
         .s     (sl_s),
         .c_msb (sl_cm),
         .co    (sl_co)
      );

      always_comb begin
         s_next                         = s_in;
         s_next[j*STAGE_W +: STAGE_W]   = sl_s;
      end

      // Data only loads with a valid beat, so bubbles never carry X forward.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            v_q[j]  <= 1'b0;
            a_q[j]  <= '0;
            b_q[j]  <= '0;
            s_q[j]  <= '0;
            c_q[j]  <= 1'b0;
            cm_q[j] <= 1'b0;
         end else if (advance) begin
            v_q[j] <= v_in;
            if (v_in) begin
               a_q[j]  <= a_in;
               b_q[j]  <= b_in;
               s_q[j]  <= s_next;
               c_q[j]  <= sl_co;
               cm_q[j] <= sl_cm;
            end
         end
      end
   end

   assign o_valid = v_q[LAST];
   assign o_s     = s_q[LAST];
   assign o_co    = c_q[LAST];
   assign o_c_msb = cm_q[LAST];
   assign o_ov    = ov_flag(c_q[LAST], cm_q[LAST]);
   assign o_z     = ~|s_q[LAST];

endmodule

// File: tb/tb_cla_pipe_ov.sv
// tb/tb_cla_pipe_ov.sv - bench for cla_pipe_ov: vector table, scoreboard, reset, stall and parameter sweep
module tb_cla_pipe_ov;

   typedef struct packed {
      logic [31:0] s;
      logic        co;
      logic        cm;
      logic        ov;
      logic        z;
   } res_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        ci;
      logic        sub;
      res_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_ready;
   logic [31:0] i_a = '0;
   logic [31:0] i_b = '0;
   logic        i_ci = 1'b0;
   logic        i_sub = 1'b0;
   logic        o_valid;
   logic        o_ready = 1'b1;
   logic [31:0] o_s;
   logic        o_co, o_c_msb, o_ov, o_z;

   int   total = 0;
   int   bad = 0;
   int   rdy_mode = 0;
   bit   sweep_on = 1'b0;
   int   scyc = 0;
   int   stall_cnt = 0;
   int   ghost;
   res_t exp_q[$];
   res_t e_pop;
   res_t stall_snap;
   bit   stalled_prev = 1'b0;
   vec_t vt[9];

   bit          acc_v   [64];
   logic [31:0] acc_a   [64];
   logic [31:0] acc_b   [64];
   logic        acc_ci  [64];
   logic        acc_sub [64];
   int          nst [5] = '{4, 8, 2, 1, 4};
   int          wd  [5] = '{32, 32, 32, 32, 16};
   int          idx;
   bit          expv;
   res_t        er;

   wire [4:0]  sw_v, sw_rdy, sw_co, sw_cm, sw_ov, sw_z;
   wire [31:0] s1_s, s2_s, s3_s;
   wire [15:0] s4_s;

   always #5 clk = ~clk;

   cla_pipe_ov #(.WIDTH(32), .STAGE_W(8)) dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready),
      .i_a(i_a), .i_b(i_b), .i_ci(i_ci), .i_sub(i_sub),
      .o_valid(o_valid), .o_ready(o_ready), .o_s(o_s), .o_co(o_co),
      .o_c_msb(o_c_msb), .o_ov(o_ov), .o_z(o_z));

   assign sw_v[0] = o_valid;   assign sw_rdy[0] = i_ready; assign sw_co[0] = o_co;
   assign sw_cm[0] = o_c_msb;  assign sw_ov[0] = o_ov;     assign sw_z[0] = o_z;

   cla_pipe_ov #(.WIDTH(32), .STAGE_W(4)) dut_s4 (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(sw_rdy[1]),
      .i_a(i_a), .i_b(i_b), .i_ci(i_ci), .i_sub(i_sub),
      .o_valid(sw_v[1]), .o_ready(1'b1), .o_s(s1_s), .o_co(sw_co[1]),
      .o_c_msb(sw_cm[1]), .o_ov(sw_ov[1]), .o_z(sw_z[1]));

   cla_pipe_ov #(.WIDTH(32), .STAGE_W(16)) dut_s16 (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(sw_rdy[2]),
      .i_a(i_a), .i_b(i_b), .i_ci(i_ci), .i_sub(i_sub),
      .o_valid(sw_v[2]), .o_ready(1'b1), .o_s(s2_s), .o_co(sw_co[2]),
      .o_c_msb(sw_cm[2]), .o_ov(sw_ov[2]), .o_z(sw_z[2]));

   cla_pipe_ov #(.WIDTH(32), .STAGE_W(32)) dut_s32 (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(sw_rdy[3]),
      .i_a(i_a), .i_b(i_b), .i_ci(i_ci), .i_sub(i_sub),
      .o_valid(sw_v[3]), .o_ready(1'b1), .o_s(s3_s), .o_co(sw_co[3]),
      .o_c_msb(sw_cm[3]), .o_ov(sw_ov[3]), .o_z(sw_z[3]));

   cla_pipe_ov #(.WIDTH(16), .STAGE_W(4)) dut_w16 (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(sw_rdy[4]),
      .i_a(i_a[15:0]), .i_b(i_b[15:0]), .i_ci(i_ci), .i_sub(i_sub),
      .o_valid(sw_v[4]), .o_ready(1'b1), .o_s(s4_s), .o_co(sw_co[4]),
      .o_c_msb(sw_cm[4]), .o_ov(sw_ov[4]), .o_z(sw_z[4]));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic ci, input logic sub, input int w);
      res_t r;
      longint unsigned mask, mlo, aa, bb, c0, full, lo;
      mask = (64'd1 << w) - 64'd1;
      mlo  = (64'd1 << (w - 1)) - 64'd1;
      aa   = {32'b0, a} & mask;
      bb   = {32'b0, (sub ? ~b : b)} & mask;
      c0   = (sub || ci) ? 64'd1 : 64'd0;
      full = aa + bb + c0;
      lo   = (aa & mlo) + (bb & mlo) + c0;
      r.s  = 32'(full & mask);
      r.co = full[w];
      r.cm = lo[w-1];
      r.ov = r.co ^ r.cm;
      r.z  = (r.s == 32'd0);
      return r;
   endfunction

   function automatic res_t cur_res();
      return {o_s, o_co, o_c_msb, o_ov, o_z};
   endfunction

   function automatic res_t sw_res(input int d);
      logic [31:0] s;
      case (d)
         0:       s = o_s;
         1:       s = s1_s;
         2:       s = s2_s;
         3:       s = s3_s;
         default: s = {16'b0, s4_s};
      endcase
      return {s, sw_co[d], sw_cm[d], sw_ov[d], sw_z[d]};
   endfunction

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic ci,
                               input logic sub, input logic [31:0] s, input logic co,
                               input logic cm, input logic ov, input logic z);
      vec_t v;
      v.a = a; v.b = b; v.ci = ci; v.sub = sub;
      v.exp = {s, co, cm, ov, z};
      return v;
   endfunction

   always @(negedge clk) begin
      case (rdy_mode)
         0:       o_ready = 1'b1;
         1:       o_ready = 1'($urandom_range(0, 1));
         default: o_ready = 1'b0;
      endcase
   end

   always @(posedge clk) begin
      if (!sweep_on) scyc <= 0;
      else           scyc <= scyc + 1;
   end

   // Scoreboard side: outputs are read one time unit after the falling edge.
   always @(negedge clk) begin
      #1;
      if (reset) begin
         stalled_prev = 1'b0;
      end else begin
         check("i_ready_eq", i_ready, !o_valid || o_ready);
         if (stalled_prev) check("stall_stable", {o_valid, cur_res()}, {1'b1, stall_snap});
         if (o_valid && o_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", o_valid, 1'b0);
            end else begin
               e_pop = exp_q.pop_front();
               check("result", cur_res(), e_pop);
            end
         end
         stalled_prev = o_valid && !o_ready;
         stall_snap   = cur_res();
      end
   end

   always @(negedge clk) begin
      #1;
      if (sweep_on && !reset) begin
         for (int d = 0; d < 5; d++) begin
            idx  = scyc - nst[d];
            expv = 1'b0;
            if (idx >= 0 && idx < 64) expv = acc_v[idx];
            check($sformatf("sweep%0d_valid", d), sw_v[d], expv);
            check($sformatf("sweep%0d_ready", d), sw_rdy[d], 1'b1);
            if (expv) begin
               er = model(acc_a[idx], acc_b[idx], acc_ci[idx], acc_sub[idx], wd[d]);
               check($sformatf("sweep%0d_data", d), sw_res(d), er);
            end
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input logic sub, input res_t e);
      int  guard;
      bit  done;
      guard = 0;
      done  = 1'b0;
      i_a = a; i_b = b; i_ci = ci; i_sub = sub; i_valid = 1'b1;
      while (!done) begin
         #1;
         if (i_ready) begin
            exp_q.push_back(e);
            if (sweep_on) begin
               acc_v[scyc] = 1'b1; acc_a[scyc] = a; acc_b[scyc] = b;
               acc_ci[scyc] = ci; acc_sub[scyc] = sub;
            end
            done = 1'b1;
         end else begin
            stall_cnt++;
            guard++;
            if (guard > 300) begin
               total++; bad++;
               $display("FAIL send_timeout: waited=%0d cycles required<=300", guard);
               done = 1'b1;
            end
         end
         @(negedge clk);
      end
      i_valid = 1'b0;
   endtask

   task automatic send_model(input logic [31:0] a, input logic [31:0] b, input logic ci,
                             input logic sub);
      send(a, b, ci, sub, model(a, b, ci, sub, 32));
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: left=%0d required=0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      vt[0] = mk(32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
      vt[1] = mk(32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1);
      vt[2] = mk(32'h5,         32'h7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
      vt[3] = mk(32'h8000_0000, 32'h1,         1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
      vt[4] = mk(32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1);
      vt[5] = mk(32'hA,         32'hA,         1'b1, 1'b1, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1);
      vt[6] = mk(32'h00FF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      vt[7] = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1);
      vt[8] = mk(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      check("rst_o_valid", o_valid, 1'b0);
      check("rst_i_ready", i_ready, 1'b1);
      check("rst_o_s",     o_s,     32'h0);
      check("rst_o_co",    o_co,    1'b0);
      check("rst_o_c_msb", o_c_msb, 1'b0);
      check("rst_o_ov",    o_ov,    1'b0);
      check("rst_o_z",     o_z,     1'b1);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) send(vt[i].a, vt[i].b, vt[i].ci, vt[i].sub, vt[i].exp);
      drain(50);

      rdy_mode = 1;
      for (int i = 0; i < 20; i++)
         send_model($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain(500);

      // Fill the pipe against a blocked sink, hold, then release.
      rdy_mode = 2;
      @(negedge clk);
      for (int i = 0; i < 4; i++) send_model(32'h100 * (i + 1), 32'h33, 1'b0, 1'(i));
      #1;
      check("full_o_valid", o_valid, 1'b1);
      check("full_i_ready", i_ready, 1'b0);
      repeat (5) @(negedge clk);
      rdy_mode = 0;
      send_model(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0);
      drain(50);

      for (int i = 0; i < 4; i++) send_model(32'h1111_0000 + i, 32'h2222_0000, 1'b0, 1'b0);
      #1;
      check("pre_reset_valid", o_valid, 1'b1);
      #1;
      reset = 1'b1;
      #1;
      check("async_o_valid", o_valid, 1'b0);
      check("async_o_s",     o_s,     32'h0);
      check("async_o_z",     o_z,     1'b1);
      check("async_i_ready", i_ready, 1'b1);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      ghost = 0;
      repeat (12) begin
         @(negedge clk);
         #1;
         if (o_valid) ghost++;
      end
      check("ghost_beats", ghost, 0);
      @(negedge clk);

      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 64; i++) acc_v[i] = 1'b0;
      stall_cnt = 0;
      sweep_on  = 1'b1;
      send_model(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      send_model(32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1);
      send_model(32'h7FFF_7FFF, 32'h0000_0001, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++)
         send_model($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("sweep_stalls", stall_cnt, 0);
      repeat (12) @(negedge clk);
      sweep_on = 1'b0;
      drain(50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
